ps2_rx: RTL and testbench
=========================

# ps2_rx

PS/2 keyboard receiver feeding the command decoder's `Dato`/`flag` inputs. Synchronizes and deglitches the PS/2 clock/data lines and deserializes 11-bit device-to-host frames. It checks start, parity and stop bits and filters break (`F0`) and extended (`E0`) sequences. Only make codes are presented, each as a held byte plus a one-cycle strobe.

## Interface
- `FILTER_LEN`, default 8: consecutive equal `ps2c` samples required to change the filtered clock level.
- `TIMEOUT_CYC`, default 5000: idle `CLK` cycles inside a frame before it is abandoned.
- `CLK` input, 1 bit: system clock, rising-edge.
- `RST` input, 1 bit: reset, asynchronous, active-high.
- `ps2c` input, 1 bit: raw PS/2 clock, asynchronous.
- `ps2d` input, 1 bit: raw PS/2 data, asynchronous.
- `Dato` output, 8 bits: last accepted make code, held until the next one.
- `flag` output, 1 bit: one-cycle pulse; new `Dato` is valid.
- `err_parity` output, 1 bit: one-cycle pulse on a parity failure.
- `err_frame` output, 1 bit: one-cycle pulse on a bad stop bit or a timeout.

## Operation
- Input path: `ps2c` and `ps2d` each pass through 2-FF synchronizers. The synchronized clock feeds a `FILTER_LEN` counter filter. A falling edge (`fall`) is a 1→0 transition of the filtered clock. The data bit is sampled from synchronized `ps2d` in the `fall` cycle.
- Frame FSM states:
  - IDLE: on `fall` with data 0 (start bit), go to SHIFT with bit count 0. On `fall` with data 1, stay in IDLE (spurious edge).
  - SHIFT: each `fall` shifts data into the register LSB-first. 8 data bits, then parity, then stop. After the stop bit, go to CHECK.
  - CHECK: one cycle, then always IDLE.
    - Data bits plus parity must have odd parity; else pulse `err_parity`.
    - Stop bit must be 1; else pulse `err_frame`.
    - If both fail, both errors pulse.
    - A valid frame is passed to the sequence filter.
- Timeout: in SHIFT, a counter is cleared on every `fall`. When it reaches `TIMEOUT_CYC`, go to IDLE, pulse `err_frame`, and discard the partial bits.
- Sequence filter (separate 2-state FSM, NORMAL / BRK):
  - Valid `E0`: discarded, no state change.
  - Valid `F0`: go to BRK, no `flag`.
  - Valid other code in BRK: discarded (release code), return to NORMAL.
  - Valid other code in NORMAL: `Dato` is loaded and `flag` pulses.
- Errored frames never change the sequence-filter state.
- `Dato` changes only in the cycle `flag` is high.
- `flag`, `err_parity` and `err_frame` are never high for more than 1 cycle.

## Timing
- Reset values: `Dato` = 8'h00; `flag`, `err_parity`, `err_frame` = 0; frame FSM in IDLE; sequence filter in NORMAL; shift register, bit count and timeout counter 0; filtered clock 1.
- `RST` asserted mid-frame aborts the frame immediately. No strobe or error fires on release.
- Edge latency: a settled `ps2c` fall produces `fall` 2 (synchronizer) + `FILTER_LEN` cycles later.
- Strobe latency: `flag` or an error pulse rises exactly 1 cycle after the `fall` cycle of the stop bit (the CHECK cycle).
- Back-to-back frames: the next start-bit `fall` is always accepted. The PS/2 bit period (≥60 µs) is far longer than CHECK.
- Glitches on `ps2c` shorter than `FILTER_LEN` cycles are ignored entirely.
- `TIMEOUT_CYC` × clock period must exceed the maximum PS/2 bit period. At a 50 MHz `CLK`, 5000 cycles = 100 µs.

## Structure
- Shared package `ps2_pkg` holds:
  - `FRAME_BITS` = 11, `BREAK_CODE` = 8'hF0, `EXT_CODE` = 8'hE0.
  - The command scan codes also used by the decoder: Enter 8'h5A, Reset 8'h2D, I 8'h43, P 8'h4D, A 8'h1C, G 8'h34, H 8'h33, Y 8'h35, N 8'h31.
  - Frame-FSM and sequence-FSM state encodings.
- Sub-module `ps2_filter` contains the synchronizers, the `FILTER_LEN` filter and the `fall` detector. Its outputs are `fall` and synchronized `data`.

## Test plan
- Frame 0x5A (parity 1, stop 1): `Dato` = 8'h5A; `flag` high exactly 1 cycle, 1 cycle after the stop-bit `fall`; no errors.
- Frames 0x43, F0, 0x43: one `flag` only, with `Dato` = 8'h43. The filter returns to NORMAL, and a following 0x2D gives `flag` with `Dato` = 8'h2D.
- Frames E0, 0x74: a single `flag` with `Dato` = 8'h74.
- Frame 0x4D with the parity bit inverted: `err_parity` 1-cycle pulse; no `flag`; `Dato` unchanged.
- Frame 0x1C with stop bit 0: `err_frame` pulse; no `flag`.
- Timeout: start bit plus 4 bits, then `ps2c` held high for `TIMEOUT_CYC`+10 cycles → `err_frame` pulse, FSM in IDLE. A following full 0x35 frame → `flag`, `Dato` = 8'h35.
- Glitch and reset:
  - A 3-cycle low pulse on `ps2c` (`FILTER_LEN` = 8) → no bit shifted; the next frame 0x31 decodes correctly.
  - `RST` asserted after 6 bits → all outputs at their reset values; the next 0x5A frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 frame constants, scan codes and FSM encodings
// Imported by ps2_filter and ps2_rx, and by the command decoder for the scan codes.
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // Command scan codes recognised by the downstream decoder
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_RESET = 8'h2D;
  localparam logic [7:0] SC_I     = 8'h43;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_G     = 8'h34;
  localparam logic [7:0] SC_H     = 8'h33;
  localparam logic [7:0] SC_Y     = 8'h35;
  localparam logic [7:0] SC_N     = 8'h31;

  typedef enum logic [1:0] {
    FR_IDLE  = 2'd0,
    FR_SHIFT = 2'd1,
    FR_CHECK = 2'd2
  } frame_state_t;

  typedef enum logic {
    SEQ_NORMAL = 1'b0,
    SEQ_BRK    = 1'b1
  } seq_state_t;

  // Data bits plus parity bit: true when the 9-bit group has odd parity
  function automatic logic parity_odd(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// rtl/ps2_filter.sv - PS/2 line synchronizers, clock deglitch filter and fall detector
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   ps2c, ps2d raw asynchronous PS/2 clock and data
//   fall       one-cycle pulse on a 1->0 transition of the filtered clock
//   data       synchronized PS/2 data, valid to sample while fall is high
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2c,
  input  logic ps2d,
  output logic fall,
  output logic data
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          c_meta_q, c_sync_q;
  logic          d_meta_q, d_sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;

  // The filtered level only flips after FILTER_LEN consecutive samples disagree with it;
  // any agreeing sample restarts the count, so short glitches never reach fall.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    fall_d = 1'b0;
    if (c_sync_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = c_sync_q;
        fall_d = filt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_meta_q <= 1'b1;
      c_sync_q <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
      filt_q   <= 1'b1;
      cnt_q    <= '0;
      fall_q   <= 1'b0;
    end else begin
      c_meta_q <= ps2c;
      c_sync_q <= c_meta_q;
      d_meta_q <= ps2d;
      d_sync_q <= d_meta_q;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      fall_q   <= fall_d;
    end
  end

  assign fall = fall_q;
  assign data = d_sync_q;

endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 keyboard receiver presenting make codes as byte plus strobe
// Ports:
//   CLK, RST    system clock, asynchronous active-high reset
//   ps2c, ps2d  raw asynchronous PS/2 clock and data
//   Dato        last accepted make code, held between strobes
//   flag        one-cycle strobe, Dato just updated
//   err_parity  one-cycle pulse on a parity failure
//   err_frame   one-cycle pulse on a bad stop bit or a mid-frame timeout
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] Dato,
  output logic       flag,
  output logic       err_parity,
  output logic       err_frame
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic fall, data;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk  (CLK),
    .rst  (RST),
    .ps2c (ps2c),
    .ps2d (ps2d),
    .fall (fall),
    .data (data)
  );

  frame_state_t  fr_q, fr_d;
  seq_state_t    seq_q, seq_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    dato_q, dato_d;
  logic          flag_q, flag_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  // The frame is judged on the stop-bit fall itself so that Dato, flag and the error
  // pulses all become visible together in the single CHECK cycle that follows.
  always_comb begin
    fr_d      = fr_q;
    seq_d     = seq_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tcnt_d    = tcnt_q;
    dato_d    = dato_q;
    flag_d    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    case (fr_q)
      FR_IDLE: begin
        if (fall && !data) begin
          fr_d      = FR_SHIFT;
          shift_d   = '0;
          bit_cnt_d = '0;
          tcnt_d    = '0;
        end
      end
      FR_SHIFT: begin
        if (fall) begin
          tcnt_d = '0;
          if (bit_cnt_q == 4'(FRAME_BITS - 2)) begin
            fr_d      = FR_CHECK;
            bit_cnt_d = '0;
            perr_d    = !parity_odd(shift_q);
            ferr_d    = !data;
            if (parity_odd(shift_q) && data) begin
              if (shift_q[7:0] == EXT_CODE) begin
                seq_d = seq_q;
              end else if (shift_q[7:0] == BREAK_CODE) begin
                seq_d = SEQ_BRK;
              end else if (seq_q == SEQ_BRK) begin
                seq_d = SEQ_NORMAL;
              end else begin
                dato_d = shift_q[7:0];
                flag_d = 1'b1;
              end
            end
          end else begin
            // LSB first: after nine shifts data sits in [7:0] and parity in [8]
            shift_d   = {data, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          fr_d      = FR_IDLE;
          ferr_d    = 1'b1;
          shift_d   = '0;
          bit_cnt_d = '0;
          tcnt_d    = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      FR_CHECK: begin
        fr_d    = FR_IDLE;
        shift_d = '0;
      end
      default: begin
        fr_d = FR_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fr_q      <= FR_IDLE;
      seq_q     <= SEQ_NORMAL;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tcnt_q    <= '0;
      dato_q    <= 8'h00;
      flag_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      fr_q      <= fr_d;
      seq_q     <= seq_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tcnt_q    <= tcnt_d;
      dato_q    <= dato_d;
      flag_q    <= flag_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign Dato       = dato_q;
  assign flag       = flag_q;
  assign err_parity = perr_q;
  assign err_frame  = ferr_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - self-checking bench for ps2_rx against a scan-code sequence model
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int FL   = 8;
  localparam int TO   = 200;
  localparam int HALF = 20;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] Dato;
  logic       flag, err_parity, err_frame;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .Dato       (Dato),
    .flag       (flag),
    .err_parity (err_parity),
    .err_frame  (err_frame)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  bit         mdl_brk = 1'b0;
  logic [7:0] mdl_dato = 8'h00;
  int         exp_flags = 0, exp_perr = 0, exp_ferr = 0;

  // Whole-run monitor
  int         seen_flags = 0, seen_perr = 0, seen_ferr = 0;
  int         wide_pulses = 0, dato_moves = 0;
  logic       prev_flag = 1'b0, prev_perr = 1'b0, prev_ferr = 1'b0;
  logic [7:0] prev_dato = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      seen_flags += int'(flag);
      seen_perr  += int'(err_parity);
      seen_ferr  += int'(err_frame);
      if ((flag && prev_flag) || (err_parity && prev_perr) || (err_frame && prev_ferr))
        wide_pulses++;
      if (Dato !== prev_dato && !flag)
        dato_moves++;
    end
    prev_flag = flag;
    prev_perr = err_parity;
    prev_ferr = err_frame;
    prev_dato = Dato;
  end

  task automatic model_frame(input logic [7:0] code, input bit bp, input bit bs,
                             output bit ef, output bit ep, output bit es);
    ef = 1'b0;
    ep = bp;
    es = bs;
    if (!bp && !bs) begin
      if (code == EXT_CODE) begin
        ef = 1'b0;
      end else if (code == BREAK_CODE) begin
        mdl_brk = 1'b1;
      end else if (mdl_brk) begin
        mdl_brk = 1'b0;
      end else begin
        ef = 1'b1;
        mdl_dato = code;
      end
    end
    exp_flags += int'(ef);
    exp_perr  += int'(ep);
    exp_ferr  += int'(es);
  endtask

  // Drives the first nbits bits of a frame; during the stop bit's low half it counts
  // the strobes and records the cycle (after the ps2c fall) of the first one.
  task automatic send_frame(input logic [7:0] code, input bit bp, input bit bs, input int nbits,
                            output int nf, output int np, output int ns, output int first);
    logic [10:0] bits;
    bits  = {1'b1 ^ bs, (~^code) ^ bp, code, 1'b0};
    nf = 0; np = 0; ns = 0; first = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge CLK);
      ps2d = bits[i];
      repeat (HALF) @(negedge CLK);
      ps2c = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge CLK);
        if (i == 10) begin
          nf += int'(flag);
          np += int'(err_parity);
          ns += int'(err_frame);
          if (first == 0 && (flag || err_parity || err_frame)) first = k;
        end
      end
      ps2c = 1'b1;
    end
    @(negedge CLK);
    ps2d = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] code, input bit bp, input bit bs);
    bit ef, ep, es;
    int nf, np, ns, first;
    model_frame(code, bp, bs, ef, ep, es);
    send_frame(code, bp, bs, 11, nf, np, ns, first);
    check_eq({tag, " flag"}, nf, int'(ef));
    check_eq({tag, " err_parity"}, np, int'(ep));
    check_eq({tag, " err_frame"}, ns, int'(es));
    if (ef || ep || es) check_eq({tag, " latency"}, first, FL + 3);
    check_eq({tag, " Dato"}, Dato, mdl_dato);
  endtask

  task automatic quiet_window(input string tag, input int cycles, input int exp_ferr_pulses);
    int nf, np, ns;
    nf = 0; np = 0; ns = 0;
    repeat (cycles) begin
      @(negedge CLK);
      nf += int'(flag);
      np += int'(err_parity);
      ns += int'(err_frame);
    end
    check_eq({tag, " flag"}, nf, 0);
    check_eq({tag, " err_parity"}, np, 0);
    check_eq({tag, " err_frame"}, ns, exp_ferr_pulses);
  endtask

  logic [7:0] cmd_codes [9];
  logic [7:0] code;
  bit         bp, bs;
  int         nf, np, ns, first;

  initial begin
    cmd_codes = '{SC_ENTER, SC_RESET, SC_I, SC_P, SC_A, SC_G, SC_H, SC_Y, SC_N};

    repeat (3) @(negedge CLK);
    check_eq("reset Dato", Dato, 8'h00);
    check_eq("reset flag", flag, 1'b0);
    check_eq("reset err_parity", err_parity, 1'b0);
    check_eq("reset err_frame", err_frame, 1'b0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    run_frame("make 5A", 8'h5A, 1'b0, 1'b0);
    run_frame("make 43", 8'h43, 1'b0, 1'b0);
    run_frame("break F0", 8'hF0, 1'b0, 1'b0);
    run_frame("release 43", 8'h43, 1'b0, 1'b0);
    run_frame("make 2D", 8'h2D, 1'b0, 1'b0);
    run_frame("ext E0", 8'hE0, 1'b0, 1'b0);
    run_frame("ext 74", 8'h74, 1'b0, 1'b0);
    run_frame("bad parity 4D", 8'h4D, 1'b1, 1'b0);
    run_frame("bad stop 1C", 8'h1C, 1'b0, 1'b1);

    // Truncated frame: start plus four data bits, then the line goes quiet
    send_frame(8'h35, 1'b0, 1'b0, 5, nf, np, ns, first);
    exp_ferr++;
    quiet_window("timeout", TO + 10, 1);
    run_frame("after timeout 35", 8'h35, 1'b0, 1'b0);

    // Short low glitch on ps2c with data low would look like a start bit if it got through
    @(negedge CLK);
    ps2d = 1'b0;
    ps2c = 1'b0;
    repeat (3) @(negedge CLK);
    ps2c = 1'b1;
    quiet_window("glitch", 30, 0);
    ps2d = 1'b1;
    run_frame("after glitch 31", 8'h31, 1'b0, 1'b0);

    // Reset in the middle of a frame
    send_frame(8'h5A, 1'b0, 1'b0, 7, nf, np, ns, first);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("mid reset Dato", Dato, 8'h00);
    check_eq("mid reset flag", flag, 1'b0);
    check_eq("mid reset err_parity", err_parity, 1'b0);
    check_eq("mid reset err_frame", err_frame, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    mdl_brk  = 1'b0;
    mdl_dato = 8'h00;
    quiet_window("reset release", 30, 0);
    run_frame("after reset 5A", 8'h5A, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 20)      code = BREAK_CODE;
      else if (r < 30) code = EXT_CODE;
      else if (r < 50) code = cmd_codes[$urandom_range(0, 8)];
      else             code = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 9) == 0);
      run_frame($sformatf("random %0d code %02h", n, code), code, bp, bs);
    end

    repeat (10) @(negedge CLK);
    check_eq("total flag pulses", seen_flags, exp_flags);
    check_eq("total err_parity pulses", seen_perr, exp_perr);
    check_eq("total err_frame pulses", seen_ferr, exp_ferr);
    check_eq("pulses wider than 1 cycle", wide_pulses, 0);
    check_eq("Dato changed without flag", dato_moves, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
